serialize_word: RTL

//  Parallel-to-serial stage feeding the serial sequence detector. Accepts W-bit

---
 rtl/detect_sequence_pkg.sv | 19 +
 rtl/serialize_word.sv | 112 +++++++++++
 2 files changed

// File: rtl/detect_sequence_pkg.sv
// Shared definitions for the serial sequence detector path.
//   W         : word width (bits per word)
//   w_t       : word type
//   SEQUENCE  : pattern the downstream detector looks for
//   ser_fsm_t : serializer state encoding
package detect_sequence_pkg;

  localparam int unsigned W = 8;

  typedef logic [W-1:0] w_t;

  localparam w_t SEQUENCE = 8'b1001_1010;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_fsm_t;

endpackage

// File: rtl/serialize_word.sv
// Parallel-to-serial stage: accepts W-bit words over valid/ready and shifts them
// out MSB first, one bit per enabled cycle, with no gap between back-to-back words.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : bit-rate strobe; the serial output only advances when high
//   in_vld    : upstream word valid
//   in_w      : upstream word
//   in_rdy    : ready; low only while the one-word pending buffer is full
//   out_r     : registered serial bit (IDLE_BIT when idle)
//   out_vld_r : out_r carries a word bit
//   busy_r    : shifting a word or holding a pending word
module serialize_word
  import detect_sequence_pkg::*;
#(
  parameter int unsigned W        = detect_sequence_pkg::W,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_vld,
  input  logic [W-1:0] in_w,
  output logic         in_rdy,
  output logic         out_r,
  output logic         out_vld_r,
  output logic         busy_r
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  ser_fsm_t        r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [W-1:0]    r_shift, w_shift_d;
  logic [W-1:0]    r_pend, w_pend_d;
  logic            r_pend_vld, w_pend_vld_d;
  logic            w_out_d, w_out_vld_d, w_busy_d;
  logic            w_accept, w_load, w_have_src;
  logic [W-1:0]    w_src;

  // Ready depends only on the pending flag, so there is no in_vld -> in_rdy path.
  assign in_rdy = ~r_pend_vld;

  always_comb begin
    w_accept   = in_vld & ~r_pend_vld;
    // A new word may start when idle or when the last bit of the current one is out.
    w_load     = en & ((r_state == IDLE) | (r_cnt == '0));
    // The pending word is older than anything arriving now, so it goes first.
    w_src      = r_pend_vld ? r_pend : in_w;
    w_have_src = r_pend_vld | w_accept;

    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_shift_d    = r_shift;
    w_out_d      = out_r;
    w_out_vld_d  = out_vld_r;
    w_pend_d     = r_pend;
    w_pend_vld_d = r_pend_vld;

    if (w_load) begin
      if (w_have_src) begin
        w_shift_d   = w_src << 1;
        w_out_d     = w_src[W-1];
        w_out_vld_d = 1'b1;
        w_cnt_d     = CntW'(W - 1);
        w_state_d   = SHIFT;
      end else begin
        w_out_d     = IDLE_BIT;
        w_out_vld_d = 1'b0;
        w_state_d   = IDLE;
      end
    end else if (en && (r_state == SHIFT)) begin
      w_out_d   = r_shift[W-1];
      w_shift_d = r_shift << 1;
      w_cnt_d   = r_cnt - 1'b1;
    end

    if (w_load && r_pend_vld) begin
      // Pending word consumed; any word accepted now refills the buffer.
      w_pend_vld_d = w_accept;
      if (w_accept) w_pend_d = in_w;
    end else if (w_accept && !w_load) begin
      w_pend_d     = in_w;
      w_pend_vld_d = 1'b1;
    end

    w_busy_d = (w_state_d == SHIFT) | w_pend_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      out_r      <= IDLE_BIT;
      out_vld_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_shift    <= w_shift_d;
      r_pend     <= w_pend_d;
      r_pend_vld <= w_pend_vld_d;
      out_r      <= w_out_d;
      out_vld_r  <= w_out_vld_d;
      busy_r     <= w_busy_d;
    end
  end

endmodule
